// File: rtl/ssd_scan_mux.sv
// Time-multiplexed seven-segment scan driver: one digit per DIV-cycle slot,
// with a dark gap at the start of each slot to suppress ghosting.
module ssd_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [8*NUM_DIGITS-1:0]         seg_in,
    input  logic [NUM_DIGITS-1:0]           blank_mask,
    output logic [7:0]                      seg_out,
    output logic [NUM_DIGITS-1:0]           an_out,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_sel,
    output logic                            frame_tick
);

    localparam int DW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(DIV);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           slot_cnt_q;
    logic [7:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [DW-1:0]           digit_q;
    logic                    tick_q;

    logic [7:0]              seg_load_d;
    logic [NUM_DIGITS-1:0]   an_load_d;

    // Pattern to latch on DRIVE entry; a masked digit stays dark for its slot.
    always_comb begin
        seg_load_d = '1;
        an_load_d  = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (digit_q == DW'(k) && !blank_mask[k]) begin
                seg_load_d   = seg_in[8*k +: 8];
                an_load_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // Reset and disable land in the same dark IDLE state.
        if (reset || !enable) begin
            state_q    <= IDLE;
            slot_cnt_q <= '0;
            seg_q      <= '1;
            an_q       <= '1;
            digit_q    <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_q    <= BLANK;
                    slot_cnt_q <= '0;
                end
                BLANK: begin
                    slot_cnt_q <= slot_cnt_q + 1'b1;
                    if (slot_cnt_q == BLANK_LAST) begin
                        state_q <= DRIVE;
                        seg_q   <= seg_load_d;
                        an_q    <= an_load_d;
                    end
                end
                DRIVE: begin
                    if (slot_cnt_q == SLOT_LAST) begin
                        state_q    <= BLANK;
                        slot_cnt_q <= '0;
                        seg_q      <= '1;
                        an_q       <= '1;
                        digit_q    <= (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
                        tick_q     <= (digit_q == DIGIT_LAST);
                    end else begin
                        slot_cnt_q <= slot_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign digit_sel  = digit_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Scoreboard bench for ssd_scan_mux: a position-in-frame model pushes the
// expected outputs for every clock edge, compared one step later.
module tb_ssd_scan_mux;

    localparam int ND = 4;
    localparam int DV = 8;
    localparam int BL = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [8*ND-1:0] seg_in;
    logic [ND-1:0]   blank_mask;
    logic [7:0]      seg_out;
    logic [ND-1:0]   an_out;
    logic [1:0]      digit_sel;
    logic            frame_tick;

    ssd_scan_mux #(
        .NUM_DIGITS  (ND),
        .DIV         (DV),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seg_in    (seg_in),
        .blank_mask(blank_mask),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    seg;
        logic [ND-1:0] an;
        logic [1:0]    ds;
        logic          ft;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Model: cycles elapsed since the scan started from IDLE.
    bit       m_active = 0;
    int       m_p      = 0;
    logic [7:0] m_snap_seg = 8'hFF;
    bit       m_snap_on  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        int   off;
        int   d;
        if (reset || !enable) begin
            m_active = 0;
            m_p      = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_p      = 0;
        end else begin
            m_p++;
        end
        e.seg = 8'hFF;
        e.an  = '1;
        e.ds  = '0;
        e.ft  = 1'b0;
        if (m_active) begin
            off  = m_p % DV;
            d    = (m_p / DV) % ND;
            e.ds = 2'(d);
            if (off == BL) begin
                m_snap_seg = seg_in[8*d +: 8];
                m_snap_on  = !blank_mask[d];
            end
            if (off >= BL && m_snap_on) begin
                e.seg   = m_snap_seg;
                e.an[d] = 1'b0;
            end
            e.ft = (m_p > 0) && (m_p % (ND*DV) == 0);
        end
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("seg_out", 32'(seg_out), 32'(e.seg));
            check("an_out", 32'(an_out), 32'(e.an));
            check("digit_sel", 32'(digit_sel), 32'(e.ds));
            check("frame_tick", 32'(frame_tick), 32'(e.ft));
        end
        check("one_anode", 32'($countones(~an_out) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int dig, input int off);
        bit found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_active && ((m_p / DV) % ND) == dig && (m_p % DV) == off) begin
                found = 1;
                break;
            end
            step();
        end
        check("reach_slot", 32'(found), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        seg_in     = {8'hF9, 8'hA4, 8'hB0, 8'hC0};
        blank_mask = '0;

        // Reset held with enable high.
        run(3);
        reset = 1'b0;
        run(8);

        // Full frames with frame_tick.
        run(72);

        // Mid-slot seg_in change must not show until the next digit-0 slot.
        run_until(0, 4);
        seg_in[7:0] = 8'h92;
        run(40);

        // Masked digit 2.
        blank_mask = 4'b0100;
        run(40);
        blank_mask = '0;

        // Enable drop during digit-2 DRIVE, then re-enable.
        run_until(2, 3);
        enable = 1'b0;
        step();
        check("disabled_dark", 32'(an_out), 32'hF);
        enable = 1'b1;
        run(40);

        // Random enable/seg_in/mask activity with one mid-run reset.
        for (int i = 0; i < 200; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            seg_in = $urandom;
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            reset = (i == 100);
            step();
        end
        reset = 1'b0;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
